// File: rtl/mem_arb.sv
// Single-port RAM arbiter shared by instruction fetch and the MEM stage, with
// load extension and store byte-lane encoding. Optional MEM_ARB_FAIR_EN adds an anti-starvation streak.
module mem_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_misalign,
    output logic        if_stall,
    output logic        mem_stall,
    output logic        ram_en,
    output logic        ram_we,
    output logic [3:0]  ram_be,
    output logic [29:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND_IF  = 2'd1,
        PEND_MEM = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        misaligned;
    logic        grant_if;
    logic        grant_mem;
    logic        reject_mem;
    logic        if_priority;
    logic [2:0]  rd_funct3;
    logic [1:0]  rd_off;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        unused_bits;

    // Fetch addresses are word-aligned; the low bits carry no information.
    assign unused_bits = ^if_addr[1:0];

`ifdef MEM_ARB_FAIR_EN
    logic [1:0] streak;

    assign if_priority = (streak == 2'd2) && if_req;

    // Count back-to-back MEM wins while fetch is kept waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= 2'd0;
        end else if (grant_if || !if_req) begin
            streak <= 2'd0;
        end else if (grant_mem && (streak != 2'd3)) begin
            streak <= streak + 2'd1;
        end else begin
            streak <= streak;
        end
    end
`else
    assign if_priority = 1'b0;
`endif

    // Alignment check on the MEM request size.
    always_comb begin
        misaligned = 1'b0;
        case (mem_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_addr[0];
            2'b10:   misaligned = |mem_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Arbitration: a rejected MEM request frees the RAM slot for fetch.
    always_comb begin
        grant_if   = 1'b0;
        grant_mem  = 1'b0;
        reject_mem = 1'b0;
        if (rst) begin
            grant_if = 1'b0;
        end else if (mem_req && misaligned) begin
            reject_mem = 1'b1;
            grant_if   = if_req;
        end else if (mem_req && !if_priority) begin
            grant_mem = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end else begin
            grant_if = 1'b0;
        end
    end

    assign if_gnt       = grant_if;
    assign mem_gnt      = grant_mem | reject_mem;
    assign mem_misalign = reject_mem;
    assign if_stall     = if_req & ~if_gnt;
    assign mem_stall    = mem_req & ~mem_gnt;

    // RAM strobe, address and store lane encoding for the granted access.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = 4'b0000;
        ram_addr  = 30'd0;
        ram_wdata = 32'd0;
        if (grant_mem) begin
            ram_en   = 1'b1;
            ram_addr = mem_addr[31:2];
            if (mem_we) begin
                ram_we = 1'b1;
                case (mem_funct3[1:0])
                    2'b00: begin
                        ram_be    = 4'b0001 << mem_addr[1:0];
                        ram_wdata = {4{mem_wdata[7:0]}};
                    end
                    2'b01: begin
                        ram_be    = 4'b0011 << {mem_addr[1], 1'b0};
                        ram_wdata = {2{mem_wdata[15:0]}};
                    end
                    default: begin
                        ram_be    = 4'b1111;
                        ram_wdata = mem_wdata;
                    end
                endcase
            end else begin
                ram_we = 1'b0;
            end
        end else if (grant_if) begin
            ram_en   = 1'b1;
            ram_addr = if_addr[31:2];
        end else begin
            ram_en = 1'b0;
        end
    end

    // Only reads leave a pending response; stores finish in their grant cycle.
    always_comb begin
        state_next = IDLE;
        if (grant_mem && !mem_we) begin
            state_next = PEND_MEM;
        end else if (grant_if) begin
            state_next = PEND_IF;
        end else begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember load size and byte offset for the response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_funct3 <= 3'd0;
            rd_off    <= 2'd0;
        end else if (grant_mem && !mem_we) begin
            rd_funct3 <= mem_funct3;
            rd_off    <= mem_addr[1:0];
        end else begin
            rd_funct3 <= rd_funct3;
            rd_off    <= rd_off;
        end
    end

    // rst masks a response already in flight.
    assign if_rvalid  = (state == PEND_IF) && !rst;
    assign mem_rvalid = (state == PEND_MEM) && !rst;
    assign if_rdata   = if_rvalid ? ram_rdata : 32'd0;

    assign rd_byte = ram_rdata[{rd_off, 3'b000} +: 8];
    assign rd_half = rd_off[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    // Load extraction and extension.
    always_comb begin
        mem_rdata = 32'd0;
        if (mem_rvalid) begin
            case (rd_funct3)
                3'b000:  mem_rdata = {{24{rd_byte[7]}}, rd_byte};
                3'b001:  mem_rdata = {{16{rd_half[15]}}, rd_half};
                3'b100:  mem_rdata = {24'd0, rd_byte};
                3'b101:  mem_rdata = {16'd0, rd_half};
                default: mem_rdata = ram_rdata;
            endcase
        end else begin
            mem_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a behavioural 1-cycle RAM.
// Fairness expectations follow MEM_ARB_FAIR_EN.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_misalign;
    logic        if_stall;
    logic        mem_stall;
    logic        ram_en;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] ram [0:255];
    int checks = 0;
    int failures = 0;

    mem_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_misalign(mem_misalign),
        .if_stall(if_stall), .mem_stall(mem_stall),
        .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with byte enables and 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) ram[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end else begin
                ram_rdata <= ram[ram_addr[7:0]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ir, input logic [31:0] ia,
                        input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] ma, input logic [31:0] wd);
        @(negedge clk);
        rst = r; if_req = ir; if_addr = ia;
        mem_req = mr; mem_we = mw; mem_funct3 = f3; mem_addr = ma; mem_wdata = wd;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    logic [31:0] ld_addr [0:5];
    logic [2:0]  ld_f3   [0:5];
    logic [31:0] ld_exp  [0:5];
    logic [31:0] if_exp  [0:2];
    logic        exp_m;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[0]  = 32'h1111_1111;
        ram[1]  = 32'h2222_2222;
        ram[2]  = 32'h3333_3333;
        ram[64] = 32'h80FF_7F01;
        ld_addr[0] = 32'h101; ld_f3[0] = 3'b000; ld_exp[0] = 32'h0000_007F;
        ld_addr[1] = 32'h102; ld_f3[1] = 3'b001; ld_exp[1] = 32'hFFFF_80FF;
        ld_addr[2] = 32'h103; ld_f3[2] = 3'b100; ld_exp[2] = 32'h0000_0080;
        ld_addr[3] = 32'h100; ld_f3[3] = 3'b010; ld_exp[3] = 32'h80FF_7F01;
        ld_addr[4] = 32'h102; ld_f3[4] = 3'b101; ld_exp[4] = 32'h0000_80FF;
        ld_addr[5] = 32'h103; ld_f3[5] = 3'b000; ld_exp[5] = 32'hFFFF_FF80;
        if_exp[0] = 32'h1111_1111; if_exp[1] = 32'h2222_2222; if_exp[2] = 32'h3333_3333;

        // Reset holds everything quiet even with both requesters active.
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        check("rst_if_gnt", if_gnt, 32'd0);
        check("rst_mem_gnt", mem_gnt, 32'd0);
        check("rst_ram_en", ram_en, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        check("rst_rvalid", {if_rvalid, mem_rvalid}, 32'd0);
        check("rst_rdata", mem_rdata | if_rdata, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);

        // Pipelined loads; the first one contends with fetch.
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) step(1'b0, i == 0, 32'h10, 1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0);
            else idle();
            if (i == 0) begin
                check("cont_if_gnt", if_gnt, 32'd0);
                check("cont_if_stall", if_stall, 32'd1);
                check("cont_ram_addr", ram_addr, 32'h40);
            end
            if (i < 6) begin
                check("ld_mem_gnt", mem_gnt, 32'd1);
                check("ld_mem_stall", mem_stall, 32'd0);
            end
            if (i > 0) begin
                check("ld_rvalid", mem_rvalid, 32'd1);
                check("ld_if_rvalid", if_rvalid, 32'd0);
                check("ld_rdata", mem_rdata, ld_exp[i-1]);
            end
        end
        idle();
        check("idle_mem_rvalid", mem_rvalid, 32'd0);
        check("idle_mem_rdata", mem_rdata, 32'd0);

        // Sub-word and word stores, then read them back.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b001, 32'h202, 32'h0000_BEEF);
        check("sh_gnt", mem_gnt, 32'd1);
        check("sh_we", ram_we, 32'd1);
        check("sh_be", ram_be, 32'hC);
        check("sh_wdata", ram_wdata, 32'hBEEF_BEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b000, 32'h201, 32'h0000_00A5);
        check("sh_no_rvalid", mem_rvalid, 32'd0);
        check("sb_be", ram_be, 32'h2);
        check("sb_wdata", ram_wdata, 32'hA5A5_A5A5);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b010, 32'h204, 32'h1234_5678);
        check("sb_no_rvalid", mem_rvalid, 32'd0);
        check("sw_be", ram_be, 32'hF);
        check("sw_wdata", ram_wdata, 32'h1234_5678);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b101, 32'h202, 32'h0);
        check("sw_no_rvalid", mem_rvalid, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        check("lhu_rdata", mem_rdata, 32'h0000_BEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0);
        check("lw_merged", mem_rdata, 32'hBEEF_A500);
        idle();
        check("lw_stored", mem_rdata, 32'h1234_5678);

        // Misaligned requests are consumed without touching RAM.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b010, 32'h3, 32'h0);
        check("mis_gnt", mem_gnt, 32'd1);
        check("mis_flag", mem_misalign, 32'd1);
        check("mis_ram_en", ram_en, 32'd0);
        step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 3'b010, 32'h3, 32'h0);
        check("mis_no_rvalid", mem_rvalid, 32'd0);
        check("mis_if_gnt", if_gnt, 32'd1);
        check("mis_if_flag", mem_misalign, 32'd1);
        check("mis_if_addr", ram_addr, 32'h40);
        check("mis_if_stall", if_stall, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 3'b001, 32'h201, 32'h0);
        check("mis_if_rvalid", if_rvalid, 32'd1);
        check("mis_if_rdata", if_rdata, 32'h80FF_7F01);
        check("mis_sh_flag", mem_misalign, 32'd1);
        check("mis_sh_we", ram_we, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        check("mis_f3_11", mem_misalign, 32'd1);
        check("mis_if_rdata_0", if_rdata, 32'd0);
        idle();

        // Back-to-back fetches.
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) step(1'b0, 1'b1, 32'(4 * i), 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            else idle();
            check("b2b_if_gnt", if_gnt, (i < 3) ? 32'd1 : 32'd0);
            if (i < 3) check("b2b_addr", ram_addr, 32'(i));
            if (i > 0) begin
                check("b2b_rvalid", if_rvalid, 32'd1);
                check("b2b_rdata", if_rdata, if_exp[i-1]);
            end
        end

        // Sustained contention.
        idle();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
`ifdef MEM_ARB_FAIR_EN
            exp_m = (i % 3) != 2;
`else
            exp_m = 1'b1;
`endif
            check("fair_mem_gnt", mem_gnt, {31'd0, exp_m});
            check("fair_if_gnt", if_gnt, {31'd0, ~exp_m});
            check("fair_if_stall", if_stall, {31'd0, exp_m});
        end
        idle();
        idle();

        // Reset while a fetch is pending drops the response.
        step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("rp_if_gnt", if_gnt, 32'd1);
        step(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 3'b010, 32'h100, 32'hFFFF_FFFF);
        check("rp_if_rvalid", if_rvalid, 32'd0);
        check("rp_if_rdata", if_rdata, 32'd0);
        check("rp_gnts", {if_gnt, mem_gnt, mem_misalign}, 32'd0);
        check("rp_ram", {ram_en, ram_we, ram_be}, 32'd0);
        check("rp_ram_addr", ram_addr, 32'd0);
        check("rp_ram_wdata", ram_wdata, 32'd0);
        idle();
        check("rp_after_rvalid", {if_rvalid, mem_rvalid}, 32'd0);
        check("rp_after_rdata", if_rdata | mem_rdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
